fft_image_seq_ctrl: RTL and testbench
=====================================

Name: fft_image_seq_ctrl

Overview:
- Sequences one FFT image context through the 4-lane 2D-FFT bank and its image memory blocks.
- Phase 1, LOAD: accepts input cachelines and pulses the FFT `next` strobe for each one. It then converts FFT `next_out` pulses into memory writes with sequential addresses.
- Phase 2, UNLOAD: after all ctx_length lines are written, it reads them back in order under output-FIFO backpressure. A per-context start/done handshake replaces free-running compare logic.

Parameters:
- ADDR_W, 13, memory address width. Maximum context is 2**ADDR_W lines.
- RD_LAT, 1, image memory read latency in cycles, from raddr presented to data valid.
- FIFO_SLACK, 2, number of free FIFO entries the downstream FIFO guarantees once full is asserted. Must be >= RD_LAT.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- start, input, 1: begins a context. Sampled only in IDLE.
- ctx_length, input, ADDR_W+1: number of lines in the context. Latched on start.
- in_valid, input, 1: an input cacheline is present this cycle.
- fft_next_out, input, 1: AND of the four FFT lanes' next_out. Marks that FFT output is valid next cycle.
- fifo_full, input, 1: output FIFO almost-full.
- fft_next, output, 1: strobe to all FFT lanes' `next`.
- mem_we, output, 1: write enable to all image memory blocks.
- mem_waddr, output, ADDR_W: write address.
- mem_raddr, output, ADDR_W: read address.
- out_valid, output, 1: cacheline_out is valid this cycle.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the last line leaves.
- err_overrun, output, 1: sticky. Set on in_valid while no line is expected. Cleared on start.

Behaviour:
- Reset values: every output is 0, state is IDLE, all counters are 0.
- Counters: in_cnt, wr_cnt and rd_cnt are each ADDR_W+1 bits wide. Address outputs are the low ADDR_W bits.
- IDLE:
  - start with ctx_length==0 gives a done pulse on the next cycle and stays in IDLE.
  - start with ctx_length>0 latches the length, clears the counters and err_overrun, and moves to LOAD.
  - ctx_length > 2**ADDR_W is clamped to 2**ADDR_W.
- LOAD:
  - fft_next = in_valid && in_cnt<len, combinational with in_valid. in_cnt increments on each accepted line.
  - in_valid when in_cnt==len sets err_overrun. The line is not forwarded.
  - When in_cnt==len, move to DRAIN.
- Write path (active in LOAD and DRAIN):
  - fft_next_out registers to mem_we, one-cycle delay. Data lands one cycle after next_out.
  - mem_waddr = wr_cnt. wr_cnt increments in the cycle mem_we is high, so the addresses for one context are 0..len-1.
  - fft_next_out while wr_cnt + mem_we == len is ignored and sets err_overrun.
- DRAIN: when wr_cnt==len and mem_we==0, move to UNLOAD.
- UNLOAD:
  - A read issues in a cycle when ~fifo_full && rd_cnt<len. It drives mem_raddr=rd_cnt and increments rd_cnt.
  - The issue flag enters an RD_LAT-deep valid pipe. out_valid is the pipe output, so it is exactly RD_LAT cycles after issue.
  - When fifo_full rises, no new read issues. Reads already in flight still emit out_valid, which is why FIFO_SLACK >= RD_LAT is required.
  - mem_raddr holds its last value while stalled.
  - When rd_cnt==len and the valid pipe is empty: pulse done, move to IDLE.
- Simultaneity:
  - start outside IDLE is ignored.
  - in_valid and fft_next_out in the same cycle are independent.
  - fifo_full toggling every cycle must not lose or duplicate any address.
- Reset mid-operation returns to IDLE next cycle, clears the valid pipe (no out_valid afterwards) and drops mem_we immediately.
- Full context: wr_cnt reaches 2**ADDR_W with no wrap error. The final mem_waddr is 2**ADDR_W-1.

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - the state enum: IDLE, LOAD, DRAIN, UNLOAD;
  - the FFT_ADDR_W constant;
  - a length type of FFT_ADDR_W+1 bits.
- One sub-module, fft_rd_valid_pipe: a RD_LAT-deep shift register of the issue flag with synchronous clear. out_valid is taken from its output.
- The FSM and counters stay in the top module.

Test Plan:
- Basic context:
  - Stimulus: start, ctx_length=4, four consecutive in_valid, FFT model next_out 3 cycles after each next, fifo_full=0.
  - Response: mem_we pulses with waddr 0,1,2,3. Then raddr 0..3 on consecutive cycles, out_valid 4 cycles back-to-back, one done pulse, busy drops.
- Backpressure:
  - Stimulus: ctx_length=8, fifo_full asserted for 3 cycles after the second read issues.
  - Response: exactly 8 out_valid and raddr sequence 0..7 with no repeats. No issue while full. The in-flight read still emits out_valid.
- Zero length:
  - Stimulus: start with ctx_length=0.
  - Response: done pulses next cycle, busy stays 0, no fft_next and no mem_we.
- Overrun:
  - Stimulus: ctx_length=2, three in_valid.
  - Response: fft_next exactly 2 times, err_overrun=1 and sticky. Next start clears it.
- Reset mid-operation:
  - Stimulus: reset asserted in UNLOAD with two reads in flight (RD_LAT=2 build).
  - Response: out_valid=0 from the next cycle, all outputs at reset values. A new context of 1 line then completes normally.
- Max length:
  - Stimulus: ADDR_W=4, ctx_length=16.
  - Response: waddr and raddr cover 0..15, done once, no err_overrun.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT image context sequencer: state codes,
// default address width and the context-length type.
package fft_ctrl_pkg;

    localparam int FFT_ADDR_W = 13;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        DRAIN  = ST_DRAIN,
        UNLOAD = ST_UNLOAD
    } fft_state_e;

    typedef logic [FFT_ADDR_W:0] fft_len_t;

endpackage

// File: rtl/fft_rd_valid_pipe.sv
// Delays the read-issue flag by the image memory read latency so the
// resulting valid lines up with the returned data.
module fft_rd_valid_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic issue,
    output logic valid,
    output logic pending
);

    logic [LAT-1:0] sr;

    always_ff @(posedge clk) begin
        if (clear) begin
            sr <= '0;
        end else begin
            sr[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign valid   = sr[LAT-1];
    assign pending = |sr;

endmodule

// File: rtl/fft_image_seq_ctrl.sv
// Sequences one image context: load lines into the FFT bank, write the FFT
// results to image memory, then read them back under FIFO backpressure.
module fft_image_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int ADDR_W     = FFT_ADDR_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_SLACK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   ctx_length,
    input  logic              in_valid,
    input  logic              fft_next_out,
    input  logic              fifo_full,
    output logic              fft_next,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err_overrun
);

    // Reads still in flight when fifo_full rises must fit in the FIFO slack.
    if (FIFO_SLACK < RD_LAT) begin : g_slack_check
        $error("fft_image_seq_ctrl: FIFO_SLACK must be >= RD_LAT");
    end

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   in_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] raddr_q;
    logic              mem_we_q;
    logic              done_q;
    logic              err_q;

    logic              write_phase;
    logic [ADDR_W:0]   wr_pending;
    logic              wr_accept;
    logic              wr_overrun;
    logic              in_overrun;
    logic              issue;
    logic              pipe_pending;
    logic              unload_done;
    logic [ADDR_W:0]   clamped_len;

    assign write_phase = (state == ST_LOAD) || (state == ST_DRAIN);
    assign wr_pending  = wr_cnt + {{ADDR_W{1'b0}}, mem_we_q};
    assign wr_accept   = write_phase && fft_next_out && (wr_pending < len);
    assign wr_overrun  = write_phase && fft_next_out && !(wr_pending < len);
    assign in_overrun  = (state != ST_IDLE) && in_valid && (in_cnt == len);
    assign fft_next    = (state == ST_LOAD) && in_valid && (in_cnt < len);
    assign issue       = (state == ST_UNLOAD) && !fifo_full && (rd_cnt < len);
    assign unload_done = (state == ST_UNLOAD) && (rd_cnt == len) && !pipe_pending;
    assign clamped_len = (ctx_length > MAX_LEN) ? MAX_LEN : ctx_length;

    // Counters advance on their own events; a start in IDLE overrides them all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            len      <= '0;
            in_cnt   <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            raddr_q  <= '0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= wr_accept;
            if (mem_we_q) wr_cnt <= wr_cnt + ONE;
            if (fft_next) in_cnt <= in_cnt + ONE;
            if (issue) begin
                rd_cnt  <= rd_cnt + ONE;
                raddr_q <= rd_cnt[ADDR_W-1:0];
            end
            if (in_overrun || wr_overrun) err_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (ctx_length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            len    <= clamped_len;
                            in_cnt <= '0;
                            wr_cnt <= '0;
                            rd_cnt <= '0;
                            state  <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD:   if (in_cnt == len) state <= ST_DRAIN;
                ST_DRAIN:  if ((wr_cnt == len) && !mem_we_q) state <= ST_UNLOAD;
                ST_UNLOAD: if (unload_done) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    fft_rd_valid_pipe #(.LAT(RD_LAT)) u_valid_pipe (
        .clk     (clk),
        .clear   (reset),
        .issue   (issue),
        .valid   (out_valid),
        .pending (pipe_pending)
    );

    assign mem_we      = mem_we_q;
    assign mem_waddr   = wr_cnt[ADDR_W-1:0];
    assign mem_raddr   = issue ? rd_cnt[ADDR_W-1:0] : raddr_q;
    assign busy        = (state != ST_IDLE);
    assign done        = done_q | unload_done;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_fft_image_seq_ctrl.sv
// Self-checking bench for fft_image_seq_ctrl (ADDR_W=4, RD_LAT=2) with an FFT
// latency model, scripted/random FIFO backpressure and a sequence-level reference.
module tb_fft_image_seq_ctrl;

    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam int SLACK = 2;
    localparam int MAXN  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, fft_next_out, fifo_full;
    logic [AW:0]   ctx_length;
    logic          fft_next, mem_we, out_valid, busy, done, err_overrun;
    logic [AW-1:0] mem_waddr, mem_raddr;

    always #5 clk = ~clk;

    fft_image_seq_ctrl #(.ADDR_W(AW), .RD_LAT(LAT), .FIFO_SLACK(SLACK)) dut (
        .clk(clk), .reset(reset), .start(start), .ctx_length(ctx_length),
        .in_valid(in_valid), .fft_next_out(fft_next_out), .fifo_full(fifo_full),
        .fft_next(fft_next), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_raddr(mem_raddr), .out_valid(out_valid), .busy(busy),
        .done(done), .err_overrun(err_overrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic          hist_nxo [256];
    logic          hist_full[256];
    logic [AW-1:0] hist_raddr[256];
    int cnt_next, cnt_ov, cnt_done, full_viol, we_viol, ov_in_full, first_ov, last_ov;
    int we_q[$];
    int rd_q[$];
    logic          nx_sample = 1'b0;
    logic [2:0]    dl = 3'b0;
    int            bp_mode = 0;
    int            bp_hold = 0;
    logic          bp_armed = 1'b0;
    logic [AW-1:0] prev_raddr = '0;

    // Observer: every out_valid must stem from an address issued LAT cycles
    // earlier while the FIFO had room; every write must follow a next_out.
    always @(negedge clk) begin
        hist_nxo[cyc & 255]   = fft_next_out;
        hist_full[cyc & 255]  = fifo_full;
        hist_raddr[cyc & 255] = mem_raddr;
        nx_sample = fft_next;
        if (fft_next) cnt_next++;
        if (mem_we) begin
            we_q.push_back(int'(mem_waddr));
            if (!hist_nxo[(cyc - 1) & 255]) we_viol++;
        end
        if (out_valid) begin
            cnt_ov++;
            rd_q.push_back(int'(hist_raddr[(cyc - LAT) & 255]));
            if (hist_full[(cyc - LAT) & 255]) full_viol++;
            if (fifo_full) ov_in_full++;
            if (first_ov < 0) first_ov = cyc;
            last_ov = cyc;
        end
        if (done) cnt_done++;
        if (bp_mode == 3 && !bp_armed && busy && prev_raddr == 0 && mem_raddr == 1) begin
            bp_hold  = 3;
            bp_armed = 1'b1;
        end
        prev_raddr = mem_raddr;
    end

    // FFT lanes answer 3 cycles after next; FIFO fullness follows bp_mode.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        dl = {dl[1:0], nx_sample};
        fft_next_out = dl[2];
        case (bp_mode)
            1: fifo_full = ($urandom_range(0, 2) == 0);
            2: fifo_full = !fifo_full;
            3: begin
                if (bp_hold > 0) begin
                    fifo_full = 1'b1;
                    bp_hold--;
                end else begin
                    fifo_full = 1'b0;
                end
            end
            default: fifo_full = 1'b0;
        endcase
    end

    task automatic clear_tallies();
        cnt_next = 0; cnt_ov = 0; cnt_done = 0; full_viol = 0; we_viol = 0;
        ov_in_full = 0; first_ov = -1; last_ov = -1; bp_armed = 1'b0;
        we_q.delete();
        rd_q.delete();
    endtask

    task automatic run_context(input int len_req, input int extra, input int gap_pct,
                               output bit timed_out);
        int n, total, sent, i;
        clear_tallies();
        n = (len_req > MAXN) ? MAXN : len_req;
        ctx_length = len_req[AW:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total = n + extra;
        sent = 0;
        while (sent < total) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        i = 0;
        while (cnt_done == 0 && i < 3000) begin
            @(posedge clk); #1;
            i++;
        end
        timed_out = (cnt_done == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; ctx_length = '0;
        fft_next_out = 1'b0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({busy, done, out_valid, mem_we, err_overrun, fft_next} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {busy, done, out_valid, mem_we, err_overrun, fft_next});
        end
        checks++;
        if (mem_waddr !== '0 || mem_raddr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_addr: got waddr %0d raddr %0d expected 0 0", mem_waddr, mem_raddr);
        end
    endtask

    task automatic test_basic();
        bit to;
        bp_mode = 0;
        run_context(4, 0, 0, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", busy); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cnt_next != 4) begin errors++; $display("[TB] FAIL basic_next: got %0d expected 4", cnt_next); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= we_q.size() || we_q[k] != k) begin
                errors++;
                $display("[TB] FAIL basic_waddr[%0d]: got %0d expected %0d", k, (k < we_q.size()) ? we_q[k] : -1, k);
            end
            checks++;
            if (k >= rd_q.size() || rd_q[k] != k) begin
                errors++;
                $display("[TB] FAIL basic_raddr[%0d]: got %0d expected %0d", k, (k < rd_q.size()) ? rd_q[k] : -1, k);
            end
        end
        checks++;
        if (cnt_ov != 4 || last_ov - first_ov != 3) begin
            errors++;
            $display("[TB] FAIL basic_ov: got count %0d span %0d expected 4 3", cnt_ov, last_ov - first_ov);
        end
        checks++;
        if (cnt_done != 1 || err_overrun !== 1'b0 || we_viol != 0) begin
            errors++;
            $display("[TB] FAIL basic_done: got done %0d err %b wviol %0d expected 1 0 0", cnt_done, err_overrun, we_viol);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        bp_mode = 3;
        run_context(8, 0, 0, to);
        repeat (3) @(posedge clk); #1;
        bp_mode = 0;
        checks++;
        if (to || cnt_ov != 8 || rd_q.size() != 8) begin
            errors++;
            $display("[TB] FAIL bp_count: got ov %0d reads %0d timeout %0d expected 8 8 0", cnt_ov, rd_q.size(), to);
        end
        for (int k = 0; k < 8 && k < rd_q.size(); k++) begin
            checks++;
            if (rd_q[k] != k) begin
                errors++;
                $display("[TB] FAIL bp_raddr[%0d]: got %0d expected %0d", k, rd_q[k], k);
            end
        end
        checks++;
        if (full_viol != 0 || ov_in_full == 0 || !bp_armed) begin
            errors++;
            $display("[TB] FAIL bp_stall: got issues_while_full %0d inflight_ov %0d armed %b expected 0 >0 1",
                     full_viol, ov_in_full, bp_armed);
        end
    endtask

    task automatic test_zero_length();
        clear_tallies();
        ctx_length = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done: got done %b busy %b expected 1 0", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_pulse: got %b expected 0", done); end
        repeat (5) @(posedge clk); #1;
        checks++;
        if (cnt_next != 0 || we_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_quiet: got next %0d we %0d busy %b expected 0 0 0", cnt_next, we_q.size(), busy);
        end
    endtask

    task automatic test_overrun();
        bit to;
        bp_mode = 0;
        run_context(2, 1, 0, to);
        checks++;
        if (to || cnt_next != 2 || we_q.size() != 2 || cnt_ov != 2) begin
            errors++;
            $display("[TB] FAIL ovr_counts: got next %0d we %0d ov %0d timeout %0d expected 2 2 2 0",
                     cnt_next, we_q.size(), cnt_ov, to);
        end
        repeat (4) @(posedge clk); #1;
        checks++;
        if (err_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b expected 1", err_overrun); end
        run_context(1, 0, 0, to);
        checks++;
        if (to || err_overrun !== 1'b0 || cnt_ov != 1) begin
            errors++;
            $display("[TB] FAIL ovr_clear: got err %b ov %0d timeout %0d expected 0 1 0", err_overrun, cnt_ov, to);
        end
    endtask

    task automatic test_reset_mid();
        int i, snap;
        bit to;
        bp_mode = 0;
        clear_tallies();
        ctx_length = 5'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        i = 0;
        while (cnt_ov == 0 && i < 200) begin @(posedge clk); #1; i++; end
        checks++;
        if (cnt_ov == 0) begin errors++; $display("[TB] FAIL rstmid_wait: got no out_valid expected out_valid"); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({busy, done, out_valid, mem_we, err_overrun} !== 5'b0 || mem_raddr !== '0 || mem_waddr !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got %b raddr %0d waddr %0d expected 00000 0 0",
                     {busy, done, out_valid, mem_we, err_overrun}, mem_raddr, mem_waddr);
        end
        snap = cnt_ov;
        repeat (6) @(posedge clk); #1;
        checks++;
        if (cnt_ov != snap) begin errors++; $display("[TB] FAIL rstmid_ghost: got %0d extra out_valid expected 0", cnt_ov - snap); end
        run_context(1, 0, 0, to);
        checks++;
        if (to || cnt_ov != 1 || rd_q.size() != 1 || rd_q[0] != 0 || we_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL rstmid_recover: got ov %0d reads %0d writes %0d timeout %0d expected 1 1 1 0",
                     cnt_ov, rd_q.size(), we_q.size(), to);
        end
    endtask

    // Random contexts (including clamped lengths) under random or toggling backpressure.
    task automatic test_random(input int iters, input int fixed_len);
        bit to;
        int len_req, n;
        for (int it = 0; it < iters; it++) begin
            len_req = (fixed_len > 0) ? fixed_len : $urandom_range(1, 2 * MAXN - 1);
            n = (len_req > MAXN) ? MAXN : len_req;
            bp_mode = (it % 2 == 0) ? 2 : 1;
            run_context(len_req, 0, 30, to);
            repeat (3) @(posedge clk); #1;
            bp_mode = 0;
            checks++;
            if (to || cnt_next != n || cnt_ov != n || cnt_done != 1) begin
                errors++;
                $display("[TB] FAIL rand_counts len=%0d: got next %0d ov %0d done %0d timeout %0d expected %0d %0d 1 0",
                         len_req, cnt_next, cnt_ov, cnt_done, to, n, n);
            end
            checks++;
            if (we_q.size() != n || rd_q.size() != n) begin
                errors++;
                $display("[TB] FAIL rand_sizes len=%0d: got writes %0d reads %0d expected %0d", len_req, we_q.size(), rd_q.size(), n);
            end
            for (int k = 0; k < n && k < we_q.size() && k < rd_q.size(); k++) begin
                checks++;
                if (we_q[k] != k || rd_q[k] != k) begin
                    errors++;
                    $display("[TB] FAIL rand_addr len=%0d [%0d]: got waddr %0d raddr %0d expected %0d",
                             len_req, k, we_q[k], rd_q[k], k);
                end
            end
            checks++;
            if (full_viol != 0 || we_viol != 0 || err_overrun !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_rules len=%0d: got fullviol %0d weviol %0d err %b busy %b expected 0 0 0 0",
                         len_req, full_viol, we_viol, err_overrun, busy);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_overrun();
        test_reset_mid();
        test_random(1, MAXN);
        test_random(1, 25);
        test_random(8, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
